// File: rtl/vga_pkg.sv
// Shared VGA timing constants, pipeline control bundle and frame-buffer
// addressing helper for the palette-code fetch path.
package vga_pkg;
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int FB_WIDTH = 160;
    localparam int ADDR_W   = 15;
    localparam int CNT_W    = 10;

    localparam logic [7:0] BLANK_CODE = 8'hFE;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic video_on;
        logic frame_start;
    } vga_ctrl_t;

    localparam vga_ctrl_t CTRL_IDLE = '{hsync: 1'b1, vsync: 1'b1, video_on: 1'b0, frame_start: 1'b0};

    // Row base for the FB_WIDTH-wide buffer: row*160 = row*128 + row*32.
    function automatic logic [ADDR_W-1:0] fb_row_base(input logic [ADDR_W-1:0] row);
        return (row << 7) + (row << 5);
    endfunction
endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical pixel counters and the stage-0 sync, video_on and
// frame_start decode, advancing only on pixel-enabled clock edges.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             pix_en_i,
    output logic [CNT_W-1:0] h_cnt_o,
    output logic [CNT_W-1:0] v_cnt_o,
    output vga_ctrl_t        ctrl_o
);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic [CNT_W-1:0] h_cnt_q;
    logic [CNT_W-1:0] h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q;
    logic [CNT_W-1:0] v_cnt_d;

    // Next count: h wraps at end of line; v steps on that wrap and wraps at end of frame.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = {CNT_W{1'b0}};
            if (v_cnt_q == V_LAST) begin
                v_cnt_d = {CNT_W{1'b0}};
            end else begin
                v_cnt_d = v_cnt_q + 1'b1;
            end
        end else begin
            h_cnt_d = h_cnt_q + 1'b1;
            v_cnt_d = v_cnt_q;
        end
    end

    // Counter registers; reset takes priority over the pixel enable.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_cnt_q <= {CNT_W{1'b0}};
            v_cnt_q <= {CNT_W{1'b0}};
        end else if (pix_en_i) begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Stage-0 decode of the current counter position.
    always_comb begin
        ctrl_o             = CTRL_IDLE;
        ctrl_o.hsync       = ~((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
        ctrl_o.vsync       = ~((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
        ctrl_o.video_on    = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
        ctrl_o.frame_start = (h_cnt_q == {CNT_W{1'b0}}) && (v_cnt_q == {CNT_W{1'b0}});
    end

    assign h_cnt_o = h_cnt_q;
    assign v_cnt_o = v_cnt_q;
endmodule

// File: rtl/vga_code_fetch.sv
// Two-stage pixel pipeline: stage 1 issues the scaled frame-buffer address,
// stage 2 captures the returned palette code with sync/video aligned to it.
module vga_code_fetch
    import vga_pkg::*;
#(
    parameter int H_ACTIVE    = vga_pkg::H_ACTIVE,
    parameter int V_ACTIVE    = vga_pkg::V_ACTIVE,
    parameter int SCALE_SHIFT = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              PIX_EN,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic [7:0]        MEM_DATA,
    output logic [7:0]        CODE,
    output logic              HSYNC,
    output logic              VSYNC,
    output logic              VIDEO_ON,
    output logic              FRAME_START
);
    logic [CNT_W-1:0]  h_cnt_s;
    logic [CNT_W-1:0]  v_cnt_s;
    vga_ctrl_t         ctrl0_s;
    vga_ctrl_t         ctrl1_q;
    vga_ctrl_t         ctrl2_q;
    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        code_d;
    logic [7:0]        code_q;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_timing (
        .clk_i    (CLK),
        .rst_i    (RST),
        .pix_en_i (PIX_EN),
        .h_cnt_o  (h_cnt_s),
        .v_cnt_o  (v_cnt_s),
        .ctrl_o   (ctrl0_s)
    );

    // Scaled row base plus scaled column; parked at 0 outside the visible area.
    always_comb begin
        addr_d = {ADDR_W{1'b0}};
        if (ctrl0_s.video_on) begin
            addr_d = fb_row_base(ADDR_W'(v_cnt_s >> SCALE_SHIFT)) + ADDR_W'(h_cnt_s >> SCALE_SHIFT);
        end else begin
            addr_d = {ADDR_W{1'b0}};
        end
    end

    // Memory data is only meaningful for a visible pixel; blanked pixels show black.
    always_comb begin
        code_d = BLANK_CODE;
        if (ctrl1_q.video_on) begin
            code_d = MEM_DATA;
        end else begin
            code_d = BLANK_CODE;
        end
    end

    // Pipeline stages 1 and 2; reset takes priority over the pixel enable.
    always_ff @(posedge CLK) begin
        if (RST) begin
            addr_q  <= {ADDR_W{1'b0}};
            ctrl1_q <= CTRL_IDLE;
            code_q  <= BLANK_CODE;
            ctrl2_q <= CTRL_IDLE;
        end else if (PIX_EN) begin
            addr_q  <= addr_d;
            ctrl1_q <= ctrl0_s;
            code_q  <= code_d;
            ctrl2_q <= ctrl1_q;
        end
    end

    assign MEM_ADDR    = addr_q;
    assign CODE        = code_q;
    assign HSYNC       = ctrl2_q.hsync;
    assign VSYNC       = ctrl2_q.vsync;
    assign VIDEO_ON    = ctrl2_q.video_on;
    assign FRAME_START = ctrl2_q.frame_start;
endmodule

// File: tb/tb_vga_code_fetch.sv
// Directed bench: a full-size 640x480 instance for reset, addressing, sync and
// pixel-rate checks, plus a small 64x16 instance for whole-frame wrap checks.
module tb_vga_code_fetch;
    localparam int HA_A = 640;
    localparam int VA_A = 480;
    localparam int HT_A = 800;
    localparam int HA_B = 64;
    localparam int VA_B = 16;
    localparam int HT_B = 224;
    localparam int VT_B = 61;
    localparam int F_B  = HT_B * VT_B;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pe  = 1'b0;
    logic [14:0] addr_a;
    logic [14:0] addr_b;
    logic [7:0]  data_a;
    logic [7:0]  data_b;
    logic [7:0]  code_a;
    logic [7:0]  code_b;
    logic        hs_a, vs_a, vo_a, fs_a;
    logic        hs_b, vs_b, vo_b, fs_b;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    // Frame-buffer model: each location holds the low byte of its own address.
    assign data_a = addr_a[7:0];
    assign data_b = addr_b[7:0];

    vga_code_fetch #(.H_ACTIVE(HA_A), .V_ACTIVE(VA_A), .SCALE_SHIFT(2)) dut_a (
        .CLK(clk), .RST(rst), .PIX_EN(pe), .MEM_ADDR(addr_a), .MEM_DATA(data_a),
        .CODE(code_a), .HSYNC(hs_a), .VSYNC(vs_a), .VIDEO_ON(vo_a), .FRAME_START(fs_a)
    );

    vga_code_fetch #(.H_ACTIVE(HA_B), .V_ACTIVE(VA_B), .SCALE_SHIFT(2)) dut_b (
        .CLK(clk), .RST(rst), .PIX_EN(pe), .MEM_ADDR(addr_b), .MEM_DATA(data_b),
        .CODE(code_b), .HSYNC(hs_b), .VSYNC(vs_b), .VIDEO_ON(vo_b), .FRAME_START(fs_b)
    );

    // Expected {code, hsync, vsync, video_on, frame_start} for pixel (h, v).
    function automatic logic [11:0] exp_out(input int h, input int v, input int ha, input int va);
        logic       vis;
        logic [7:0] c;
        int         a;
        vis = (h < ha) && (v < va);
        a   = (v / 4) * 160 + (h / 4);
        c   = vis ? a[7:0] : 8'hFE;
        return {c, !(h >= ha + 16 && h < ha + 112), !(v >= va + 10 && v < va + 12), vis, (h == 0 && v == 0)};
    endfunction

    function automatic logic [14:0] exp_addr(input int h, input int v, input int ha, input int va);
        int a;
        a = (v / 4) * 160 + (h / 4);
        return ((h < ha) && (v < va)) ? 15'(a) : 15'd0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pe  = 1'b0;
        step();
        checks++;
        if ({code_a, hs_a, vs_a, vo_a, fs_a} !== {8'hFE, 1'b1, 1'b1, 1'b0, 1'b0})
            $display("FAIL reset_no_pixen: got %h expected %h", {code_a, hs_a, vs_a, vo_a, fs_a}, {8'hFE, 4'b1100});
        pe = 1'b1;
        step();
        step();
        checks++;
        if ({code_a, hs_a, vs_a, vo_a, fs_a} !== {8'hFE, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", {code_a, hs_a, vs_a, vo_a, fs_a}, {8'hFE, 4'b1100});
        end
        checks++;
        if (addr_a !== 15'd0) begin
            errors++;
            $display("FAIL reset_addr: got %0d expected 0", addr_a);
        end
        rst = 1'b0;
        step();
        checks++;
        if ({addr_a, code_a, fs_a} !== {15'd0, 8'hFE, 1'b0}) begin
            errors++;
            $display("FAIL first_edge: addr=%0d code=%h fs=%b expected addr=0 code=fe fs=0", addr_a, code_a, fs_a);
        end
        step();
        checks++;
        if ({code_a, vo_a, fs_a} !== {8'h00, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL first_pixel: code=%h vo=%b fs=%b expected code=00 vo=1 fs=1", code_a, vo_a, fs_a);
        end
    endtask

    // Continues straight after test_reset: output pixel index = edge index - 2.
    task automatic test_first_lines();
        int p, p1, h, v;
        int hs_first, hs_low, blank, fs_extra;
        logic [11:0] e;
        hs_first = -1;
        hs_low   = 0;
        blank    = 0;
        fs_extra = 0;
        for (int k = 3; k <= 2 + 5 * HT_A; k++) begin
            step();
            p  = k - 2;
            h  = p % HT_A;
            v  = p / HT_A;
            p1 = k - 1;
            e  = exp_out(h, v, HA_A, VA_A);
            checks++;
            if ({code_a, hs_a, vs_a, vo_a, fs_a} !== e) begin
                errors++;
                $display("FAIL pixel_a(%0d,%0d): got %h expected %h", h, v, {code_a, hs_a, vs_a, vo_a, fs_a}, e);
            end
            checks++;
            if (addr_a !== exp_addr(p1 % HT_A, p1 / HT_A, HA_A, VA_A)) begin
                errors++;
                $display("FAIL addr_a(%0d,%0d): got %0d expected %0d", p1 % HT_A, p1 / HT_A, addr_a,
                         exp_addr(p1 % HT_A, p1 / HT_A, HA_A, VA_A));
            end
            if (v == 0 && hs_a == 1'b0) begin
                if (hs_first < 0) hs_first = h;
                hs_low++;
            end
            if (v == 0 && h >= 640 && code_a == 8'hFE) blank++;
            if (fs_a) fs_extra++;
            if (h == 4 && v == 0) begin
                checks++;
                if (code_a !== 8'h01) begin
                    errors++;
                    $display("FAIL code_h4v0: got %h expected 01", code_a);
                end
            end
            if (p1 == 4 * HT_A) begin
                checks++;
                if (addr_a !== 15'd160) begin
                    errors++;
                    $display("FAIL addr_h0v4: got %0d expected 160", addr_a);
                end
            end
        end
        checks++;
        if (hs_first != 656 || hs_low != 96) begin
            errors++;
            $display("FAIL hsync_window: start=%0d width=%0d expected start=656 width=96", hs_first, hs_low);
        end
        checks++;
        if (blank != 160) begin
            errors++;
            $display("FAIL hblank_code: got %0d blank pixels expected 160", blank);
        end
        checks++;
        if (fs_extra != 0) begin
            errors++;
            $display("FAIL frame_start_extra: got %0d extra pulses expected 0", fs_extra);
        end
    endtask

    task automatic test_half_rate();
        int p, p1;
        logic [11:0] e;
        rst = 1'b1;
        pe  = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 1; k <= 2 * HT_A + 2; k++) begin
            pe = 1'b1;
            step();
            p  = k - 2;
            p1 = k - 1;
            e  = (k == 1) ? {8'hFE, 1'b1, 1'b1, 1'b0, 1'b0} : exp_out(p % HT_A, p / HT_A, HA_A, VA_A);
            checks++;
            if ({code_a, hs_a, vs_a, vo_a, fs_a} !== e || addr_a !== exp_addr(p1 % HT_A, p1 / HT_A, HA_A, VA_A)) begin
                errors++;
                $display("FAIL half_rate_edge%0d: got %h/%0d expected %h/%0d", k, {code_a, hs_a, vs_a, vo_a, fs_a},
                         addr_a, e, exp_addr(p1 % HT_A, p1 / HT_A, HA_A, VA_A));
            end
            pe = 1'b0;
            step();
            checks++;
            if ({code_a, hs_a, vs_a, vo_a, fs_a} !== e || addr_a !== exp_addr(p1 % HT_A, p1 / HT_A, HA_A, VA_A)) begin
                errors++;
                $display("FAIL half_rate_hold%0d: got %h/%0d expected %h/%0d", k, {code_a, hs_a, vs_a, vo_a, fs_a},
                         addr_a, e, exp_addr(p1 % HT_A, p1 / HT_A, HA_A, VA_A));
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [11:0] e;
        rst = 1'b1;
        pe  = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 1; k <= 3 * HT_A + 300; k++) step();
        checks++;
        if (dut_a.u_timing.h_cnt_q !== 10'd300 || dut_a.u_timing.v_cnt_q !== 10'd3) begin
            errors++;
            $display("FAIL mid_position: got (%0d,%0d) expected (300,3)", dut_a.u_timing.h_cnt_q, dut_a.u_timing.v_cnt_q);
        end
        rst = 1'b1;
        pe  = 1'b0;
        step();
        checks++;
        if ({addr_a, code_a, hs_a, vs_a, vo_a, fs_a} !== {15'd0, 8'hFE, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset_outputs: got addr=%0d ctl=%h expected addr=0 ctl=fec", addr_a, {code_a, hs_a, vs_a, vo_a, fs_a});
        end
        checks++;
        if (dut_a.u_timing.h_cnt_q !== 10'd0 || dut_a.u_timing.v_cnt_q !== 10'd0) begin
            errors++;
            $display("FAIL mid_reset_counters: got (%0d,%0d) expected (0,0)", dut_a.u_timing.h_cnt_q, dut_a.u_timing.v_cnt_q);
        end
        rst = 1'b0;
        pe  = 1'b1;
        step();
        checks++;
        if ({addr_a, code_a, fs_a} !== {15'd0, 8'hFE, 1'b0}) begin
            errors++;
            $display("FAIL mid_release_edge1: addr=%0d code=%h fs=%b expected 0/fe/0", addr_a, code_a, fs_a);
        end
        for (int k = 2; k <= 8; k++) begin
            step();
            e = exp_out(k - 2, 0, HA_A, VA_A);
            checks++;
            if ({code_a, hs_a, vs_a, vo_a, fs_a} !== e) begin
                errors++;
                $display("FAIL mid_restart_pixel%0d: got %h expected %h", k - 2, {code_a, hs_a, vs_a, vo_a, fs_a}, e);
            end
        end
    endtask

    task automatic test_wrap();
        int p, p1, fs_cnt, vs_low, max_addr;
        int fs_pos[3];
        logic [11:0] e;
        fs_cnt   = 0;
        vs_low   = 0;
        max_addr = 0;
        fs_pos   = '{0, 0, 0};
        rst = 1'b1;
        pe  = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 1; k <= 2 * F_B + 4; k++) begin
            step();
            p1 = (k - 1) % F_B;
            checks++;
            if (addr_b !== exp_addr(p1 % HT_B, p1 / HT_B, HA_B, VA_B)) begin
                errors++;
                $display("FAIL addr_b(%0d,%0d): got %0d expected %0d", p1 % HT_B, p1 / HT_B, addr_b,
                         exp_addr(p1 % HT_B, p1 / HT_B, HA_B, VA_B));
            end
            if (int'(addr_b) > max_addr) max_addr = int'(addr_b);
            if (k >= 2) begin
                p = (k - 2) % F_B;
                e = exp_out(p % HT_B, p / HT_B, HA_B, VA_B);
                checks++;
                if ({code_b, hs_b, vs_b, vo_b, fs_b} !== e) begin
                    errors++;
                    $display("FAIL pixel_b(%0d,%0d): got %h expected %h", p % HT_B, p / HT_B, {code_b, hs_b, vs_b, vo_b, fs_b}, e);
                end
                if (k < 2 + F_B && vs_b == 1'b0) vs_low++;
                if (k < 2 + F_B && p == 15 * HT_B + 63) begin
                    checks++;
                    if (code_b !== 8'hEF) begin
                        errors++;
                        $display("FAIL code_last_visible: got %h expected ef", code_b);
                    end
                end
            end
            if (fs_b) begin
                if (fs_cnt < 3) fs_pos[fs_cnt] = k;
                fs_cnt++;
            end
            if (k == F_B - 1) begin
                checks++;
                if (dut_b.u_timing.h_cnt_q !== 10'd223 || dut_b.u_timing.v_cnt_q !== 10'd60) begin
                    errors++;
                    $display("FAIL pre_wrap: got (%0d,%0d) expected (223,60)", dut_b.u_timing.h_cnt_q, dut_b.u_timing.v_cnt_q);
                end
            end
            if (k == F_B) begin
                checks++;
                if (dut_b.u_timing.h_cnt_q !== 10'd0 || dut_b.u_timing.v_cnt_q !== 10'd0) begin
                    errors++;
                    $display("FAIL post_wrap: got (%0d,%0d) expected (0,0)", dut_b.u_timing.h_cnt_q, dut_b.u_timing.v_cnt_q);
                end
            end
        end
        checks++;
        if (fs_cnt != 3 || fs_pos[0] != 2 || fs_pos[1] - fs_pos[0] != F_B || fs_pos[2] - fs_pos[1] != F_B) begin
            errors++;
            $display("FAIL frame_start_period: count=%0d at %0d,%0d,%0d expected 3 at 2,%0d,%0d",
                     fs_cnt, fs_pos[0], fs_pos[1], fs_pos[2], 2 + F_B, 2 + 2 * F_B);
        end
        checks++;
        if (vs_low != 2 * HT_B) begin
            errors++;
            $display("FAIL vsync_width: got %0d pixels expected %0d", vs_low, 2 * HT_B);
        end
        checks++;
        if (max_addr != 495) begin
            errors++;
            $display("FAIL max_addr: got %0d expected 495", max_addr);
        end
    endtask

    initial begin
        test_reset();
        test_first_lines();
        test_half_rate();
        test_mid_reset();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
